// File: rtl/riscv_pkg.sv
// Shared RISC-V fetch definitions: data widths, instruction field positions
// and the fetch FSM state encoding.
package riscv_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned INSTR_W = 32;

  // Instruction field positions consumed by the control decoder
  localparam int unsigned OP_LSB     = 0;
  localparam int unsigned OP_W       = 7;
  localparam int unsigned FUNCT3_LSB = 12;
  localparam int unsigned FUNCT3_W   = 3;
  localparam int unsigned FUNCT7_BIT = 30;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StHold,
    StFault
  } fetch_state_e;

endpackage

// File: rtl/pc_next.sv
// Next-PC selection: sequential increment or branch/jump target, plus
// alignment handling. Behaviour depends on FETCH_MISALIGN_TRAP_EN: when
// defined, a misaligned next PC is flagged; otherwise its low bits are cleared.
module pc_next
  import riscv_pkg::*;
(
  input  logic [XLEN-1:0] pc,
  input  logic            pc_src,
  input  logic [XLEN-1:0] pc_target,
  output logic [XLEN-1:0] pc_plus4,
  output logic [XLEN-1:0] next_pc,
  output logic            misaligned
);

  logic [XLEN-1:0] raw_pc;

  // Select the candidate PC, then either flag or squash misalignment
  always_comb begin
    pc_plus4 = pc + XLEN'(4);  // wraps modulo 2^32
    raw_pc   = pc_src ? pc_target : pc_plus4;
`ifdef FETCH_MISALIGN_TRAP_EN
    next_pc    = raw_pc;
    misaligned = (raw_pc[1:0] != 2'b00);
`else
    next_pc    = raw_pc & ~XLEN'(3);
    misaligned = 1'b0;
`endif
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: requests one word per instruction from instruction
// memory, holds it for the decoder until downstream consumes it, then selects
// the next PC. Optional misaligned-target trap enabled by FETCH_MISALIGN_TRAP_EN.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst,
  output logic                imem_req,
  output logic [XLEN-1:0]     imem_addr,
  input  logic                imem_ack,
  input  logic [INSTR_W-1:0]  imem_rdata,
  input  logic                stall,
  input  logic                PCSrc,
  input  logic [XLEN-1:0]     PCTarget,
  output logic                instr_valid,
  output logic [INSTR_W-1:0]  instr,
  output logic [OP_W-1:0]     op,
  output logic [FUNCT3_W-1:0] funct3,
  output logic                funct7,
  output logic [XLEN-1:0]     pc,
  output logic [XLEN-1:0]     pc_plus4,
  output logic                misalign_fault
);

  fetch_state_e        state_q, state_d;
  logic [XLEN-1:0]     pc_q;
  logic [INSTR_W-1:0]  instr_q;
  logic [XLEN-1:0]     next_pc;
  logic                misaligned;
  logic                load_instr;
  logic                advance;

  pc_next u_pc_next (
    .pc         (pc_q),
    .pc_src     (PCSrc),
    .pc_target  (PCTarget),
    .pc_plus4   (pc_plus4),
    .next_pc    (next_pc),
    .misaligned (misaligned)
  );

  // Only accept the ack while a request is outstanding; consume only when unstalled
  assign load_instr = (state_q == StReq) && imem_ack;
  assign advance    = (state_q == StHold) && !stall;

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  state_d = StReq;
      StReq:   if (imem_ack) state_d = StHold;
      StHold:  if (!stall) state_d = misaligned ? StFault : StReq;
      StFault: state_d = StFault;  // only rst leaves FAULT
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    imem_req    = (state_q == StReq);
    instr_valid = (state_q == StHold);
`ifdef FETCH_MISALIGN_TRAP_EN
    misalign_fault = (state_q == StFault);
`else
    misalign_fault = 1'b0;
`endif
  end

  // PC and instruction holding registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      instr_q <= '0;
    end else begin
      if (load_instr) instr_q <= imem_rdata;
      // A faulting target is not committed, so pc keeps the last good address
      if (advance && !misaligned) pc_q <= next_pc;
    end
  end

  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign instr     = instr_q;
  assign op        = instr_q[OP_LSB +: OP_W];
  assign funct3    = instr_q[FUNCT3_LSB +: FUNCT3_W];
  assign funct7    = instr_q[FUNCT7_BIT];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit. Expectations depend on
// FETCH_MISALIGN_TRAP_EN in the misaligned-target step.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        pc_src;
  logic [31:0] pc_target;
  logic        instr_valid;
  logic [31:0] instr;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        funct7;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        misalign_fault;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_unit #(
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .stall          (stall),
    .PCSrc          (pc_src),
    .PCTarget       (pc_target),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .op             (op),
    .funct3         (funct3),
    .funct7         (funct7),
    .pc             (pc),
    .pc_plus4       (pc_plus4),
    .misalign_fault (misalign_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_req"},   {31'b0, imem_req},       32'h0);
    check({tag, "_valid"}, {31'b0, instr_valid},    32'h0);
    check({tag, "_instr"}, instr,                   32'h0);
    check({tag, "_pc"},    pc,                      32'h0);
    check({tag, "_fault"}, {31'b0, misalign_fault}, 32'h0);
  endtask

  initial begin
    rst        = 1'b1;
    imem_ack   = 1'b1;
    imem_rdata = 32'h0000_0013;
    stall      = 1'b0;
    pc_src     = 1'b0;
    pc_target  = 32'h0;
    tick();
    tick();
    check_reset("por");

    // Zero-wait memory: addresses 0,4,8 with valid every other cycle
    rst = 1'b0;
    tick();
    check("seq_req0", {31'b0, imem_req}, 32'h1);
    check("seq_addr0", imem_addr, 32'h0);
    check("seq_nvalid0", {31'b0, instr_valid}, 32'h0);
    imem_rdata = 32'h0010_0093;
    tick();
    check("seq_valid0", {31'b0, instr_valid}, 32'h1);
    check("seq_instr0", instr, 32'h0010_0093);
    check("seq_noreq0", {31'b0, imem_req}, 32'h0);
    check("seq_pc4_0", pc_plus4, 32'h4);
    tick();
    check("seq_addr4", imem_addr, 32'h4);
    check("seq_nvalid4", {31'b0, instr_valid}, 32'h0);
    tick();
    check("seq_valid4", {31'b0, instr_valid}, 32'h1);
    check("seq_pc4", pc, 32'h4);
    tick();
    check("seq_addr8", imem_addr, 32'h8);
    check("seq_req8", {31'b0, imem_req}, 32'h1);

    // Delayed ack: request held for 4 cycles in total
    imem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("wait_req", {31'b0, imem_req}, 32'h1);
      check("wait_addr", imem_addr, 32'h8);
      check("wait_nvalid", {31'b0, instr_valid}, 32'h0);
    end
    imem_ack   = 1'b1;
    imem_rdata = 32'h4000_0033;
    tick();
    check("late_valid", {31'b0, instr_valid}, 32'h1);
    check("late_instr", instr, 32'h4000_0033);

    // Stall holds instruction and fields; PCSrc ignored while stalled
    stall     = 1'b1;
    pc_src    = 1'b1;
    pc_target = 32'h300;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_op", {25'b0, op}, 32'h33);
      check("stall_f3", {29'b0, funct3}, 32'h0);
      check("stall_f7", {31'b0, funct7}, 32'h1);
      check("stall_valid", {31'b0, instr_valid}, 32'h1);
      check("stall_noreq", {31'b0, imem_req}, 32'h0);
      check("stall_pc", pc, 32'h8);
    end

    // Branch taken from HOLD; PCSrc during REQ has no effect
    stall     = 1'b0;
    pc_target = 32'h100;
    tick();
    check("br_addr", imem_addr, 32'h100);
    imem_ack  = 1'b0;
    pc_target = 32'h500;
    tick();
    check("br_req_ignore", imem_addr, 32'h100);
    imem_ack   = 1'b1;
    pc_src     = 1'b0;
    imem_rdata = 32'h0000_0013;
    tick();
    check("br_pc", pc, 32'h100);
    check("br_pc4", pc_plus4, 32'h104);

    // PC wrap at top of address space
    pc_src    = 1'b1;
    pc_target = 32'hFFFF_FFFC;
    tick();
    check("wrap_addr_top", imem_addr, 32'hFFFF_FFFC);
    pc_src = 1'b0;
    tick();
    check("wrap_pc4", pc_plus4, 32'h0);
    tick();
    check("wrap_addr0", imem_addr, 32'h0);
    tick();
    check("wrap_pc0", pc, 32'h0);

    // Misaligned branch target
    pc_src    = 1'b1;
    pc_target = 32'h102;
    tick();
`ifdef FETCH_MISALIGN_TRAP_EN
    check("mis_fault", {31'b0, misalign_fault}, 32'h1);
    check("mis_noreq", {31'b0, imem_req}, 32'h0);
    check("mis_nvalid", {31'b0, instr_valid}, 32'h0);
    pc_src = 1'b0;
    tick();
    tick();
    check("mis_stay_fault", {31'b0, misalign_fault}, 32'h1);
    check("mis_stay_noreq", {31'b0, imem_req}, 32'h0);
`else
    check("mis_addr", imem_addr, 32'h100);
    check("mis_nofault", {31'b0, misalign_fault}, 32'h0);
    imem_ack = 1'b0;
    pc_src   = 1'b0;
    tick();
    check("mis_req_hold", imem_addr, 32'h100);
`endif

    // Asynchronous reset from a non-reset state
    imem_ack = 1'b0;
    rst      = 1'b1;
    #2;
    check_reset("rst_async");
    tick();
    rst = 1'b0;
    tick();
    check("refetch_req", {31'b0, imem_req}, 32'h1);
    check("refetch_addr", imem_addr, 32'h0);
    tick();

    // Reset mid-request, then a stale ack after release
    rst = 1'b1;
    #2;
    check("midreq_noreq", {31'b0, imem_req}, 32'h0);
    tick();
    rst        = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = 32'h00A0_0113;
    tick();
    check("stale_req", {31'b0, imem_req}, 32'h1);
    check("stale_nvalid", {31'b0, instr_valid}, 32'h0);
    check("stale_instr", instr, 32'h0);
    tick();
    check("post_valid", {31'b0, instr_valid}, 32'h1);
    check("post_instr", instr, 32'h00A0_0113);
    check("post_pc", pc, 32'h0);
    tick();
    check("post_addr4", imem_addr, 32'h4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
